// File: rtl/instruction_encoder_if.sv
// Bundles the producer-side field handshake and the consumer-side packed
// instruction stream of the instruction encoder.
// Ports: enable_i/ready_o valid-ready handshake with decoded fields in;
//        Instruction_o/InstructionFormat_o/enable_o out with shouldStalled_i hold;
//        truncErr_o sticky truncation flag. slave = encoder view, master = driver view.
interface instruction_encoder_if;
   logic        enable_i;
   logic        ready_o;
   logic        instructionFormat_i;
   logic        isBranch_i;
   logic [6:0]  opcode_i;
   logic [4:0]  primOperand_i;
   logic [15:0] secOperand_i;
   logic        shouldStalled_i;
   logic [29:0] Instruction_o;
   logic        InstructionFormat_o;
   logic        enable_o;
   logic        truncErr_o;

   modport slave (
      input  enable_i, instructionFormat_i, isBranch_i, opcode_i,
             primOperand_i, secOperand_i, shouldStalled_i,
      output ready_o, Instruction_o, InstructionFormat_o, enable_o, truncErr_o
   );

   modport master (
      output enable_i, instructionFormat_i, isBranch_i, opcode_i,
             primOperand_i, secOperand_i, shouldStalled_i,
      input  ready_o, Instruction_o, InstructionFormat_o, enable_o, truncErr_o
   );
endinterface

// File: rtl/instruction_encoder.sv
// Packs decoded instruction fields into a 30-bit word and queues them in a DEPTH-entry FIFO.
// Latency: an entry accepted at edge E appears on the outputs after edge E+1 (no bypass).
// Backpressure: ready_o drops when the FIFO is full; shouldStalled_i freezes the outputs and pops.
// Ports: clock_i, reset_i (sync, active-high), bus (instruction_encoder_if.slave).
module instruction_encoder #(
   parameter int DEPTH = 4
) (
   input logic                  clock_i,
   input logic                  reset_i,
   instruction_encoder_if.slave bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   // Each entry: {format bit, packed 30-bit word}.
   logic [30:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic [29:0] instr_q;
   logic        fmt_q;
   logic        en_q;
   logic        trunc_q;

   logic        ready;
   logic        push;
   logic        pop;
   logic        trunc_hit;
   logic [29:0] packed_word;

   // Derived from registered count only, so no combinational path from the inputs.
   assign ready = (count != FULL);
   assign push  = bus.enable_i & ready;
   // Pop decision uses the registered count; a push this edge cannot be popped until the next.
   assign pop   = ~bus.shouldStalled_i & (count != '0);

   // Format 0 carries only a 5-bit register in the operand field; any upper bits are lost.
   assign trunc_hit = ~bus.instructionFormat_i & (bus.secOperand_i[15:5] != 11'd0);

   always_comb begin
      packed_word        = '0;
      packed_word[28]    = bus.isBranch_i;
      packed_word[27:21] = bus.opcode_i;
      packed_word[20:16] = bus.primOperand_i;
      if (bus.instructionFormat_i) begin
         packed_word[15:0] = bus.secOperand_i;
      end else begin
         packed_word[15:11] = bus.secOperand_i[4:0];
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clock_i) begin
      if (!reset_i && push) begin
         mem[wr_ptr] <= {bus.instructionFormat_i, packed_word};
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         instr_q <= '0;
         fmt_q   <= 1'b0;
         en_q    <= 1'b0;
         trunc_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (trunc_hit) begin
               trunc_q <= 1'b1;
            end
         end

         if (pop) begin
            {fmt_q, instr_q} <= mem[rd_ptr];
            rd_ptr           <= rd_ptr + PTR_W'(1);
            en_q             <= 1'b1;
         end else if (!bus.shouldStalled_i) begin
            // Empty and not stalled: drop valid but keep the last word visible.
            en_q <= 1'b0;
         end

         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign bus.ready_o             = ready;
   assign bus.Instruction_o       = instr_q;
   assign bus.InstructionFormat_o = fmt_q;
   assign bus.enable_o            = en_q;
   assign bus.truncErr_o          = trunc_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder with a queue scoreboard and cycle model.
// Ports exercised: all of instruction_encoder_if plus clock_i/reset_i.
module tb_instruction_encoder;
   localparam int DEPTH = 4;

   logic clk;
   logic rst;

   instruction_encoder_if bus ();

   instruction_encoder #(.DEPTH(DEPTH)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Scoreboard: {format, word} pushed on accept, popped when the model expects an output.
   logic [30:0] q[$];
   int          maxq = 0;
   logic        m_en = 1'b0;
   logic [29:0] m_word = '0;
   logic        m_fmt = 1'b0;
   logic        m_trunc = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [29:0] pack(input logic fmt, input logic br, input logic [6:0] op,
                                        input logic [4:0] prim, input logic [15:0] sec);
      logic [29:0] w;
      w = '0;
      w[28] = br;
      w[27:21] = op;
      w[20:16] = prim;
      if (fmt) w[15:0] = sec;
      else     w[15:11] = sec[4:0];
      return w;
   endfunction

   // Cycle model: evaluates what each edge must do from the inputs seen at that edge.
   logic        s_push;
   logic        s_pop;
   logic [30:0] ent;
   always @(posedge clk) begin
      s_push = bus.enable_i && (q.size() != DEPTH);
      s_pop  = !bus.shouldStalled_i && (q.size() != 0);
      if (rst) begin
         q.delete();
         m_en = 1'b0; m_word = '0; m_fmt = 1'b0; m_trunc = 1'b0;
      end else begin
         if (s_pop) begin
            ent = q.pop_front();
            m_fmt = ent[30]; m_word = ent[29:0]; m_en = 1'b1;
         end else if (!bus.shouldStalled_i) begin
            m_en = 1'b0;
         end
         if (s_push) begin
            q.push_back({bus.instructionFormat_i,
                         pack(bus.instructionFormat_i, bus.isBranch_i, bus.opcode_i,
                              bus.primOperand_i, bus.secOperand_i)});
            if (!bus.instructionFormat_i && bus.secOperand_i[15:5] != 11'd0) m_trunc = 1'b1;
         end
         if (q.size() > maxq) maxq = q.size();
      end
      #1;
      check("mon_enable_o", 32'(bus.enable_o), 32'(m_en));
      check("mon_instruction_o", 32'(bus.Instruction_o), 32'(m_word));
      check("mon_format_o", 32'(bus.InstructionFormat_o), 32'(m_fmt));
      check("mon_trunc_err_o", 32'(bus.truncErr_o), 32'(m_trunc));
      check("mon_ready_o", 32'(bus.ready_o), 32'(q.size() != DEPTH));
   end

   task automatic drive(input logic fmt, input logic br, input logic [6:0] op,
                        input logic [4:0] prim, input logic [15:0] sec);
      bus.enable_i = 1'b1;
      bus.instructionFormat_i = fmt;
      bus.isBranch_i = br;
      bus.opcode_i = op;
      bus.primOperand_i = prim;
      bus.secOperand_i = sec;
   endtask

   task automatic idle();
      bus.enable_i = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.enable_i = 1'b0;
      bus.instructionFormat_i = 1'b0;
      bus.isBranch_i = 1'b0;
      bus.opcode_i = '0;
      bus.primOperand_i = '0;
      bus.secOperand_i = '0;
      bus.shouldStalled_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_enable_o", 32'(bus.enable_o), 32'd0);
      check("rst_instruction_o", 32'(bus.Instruction_o), 32'd0);
      check("rst_trunc_err_o", 32'(bus.truncErr_o), 32'd0);
      check("rst_ready_o", 32'(bus.ready_o), 32'd1);
      rst = 1'b0;

      // Immediate-format word, one-edge latency with no bypass.
      drive(1'b1, 1'b1, 7'h05, 5'd3, 16'hBEEF);
      @(negedge clk);
      idle();
      check("no_bypass_enable_o", 32'(bus.enable_o), 32'd0);
      @(negedge clk);
      check("imm_word", 32'(bus.Instruction_o), 32'h10A3BEEF);
      check("imm_format", 32'(bus.InstructionFormat_o), 32'd1);
      check("imm_enable_o", 32'(bus.enable_o), 32'd1);
      @(negedge clk);
      check("imm_enable_drop", 32'(bus.enable_o), 32'd0);
      check("imm_word_hold", 32'(bus.Instruction_o), 32'h10A3BEEF);

      // Register format, clean then truncating operand.
      drive(1'b0, 1'b0, 7'h12, 5'd31, 16'h0015);
      @(negedge clk);
      idle();
      @(negedge clk);
      check("reg_word", 32'(bus.Instruction_o), 32'h025FA800);
      check("reg_format", 32'(bus.InstructionFormat_o), 32'd0);
      check("reg_trunc_clear", 32'(bus.truncErr_o), 32'd0);
      drive(1'b0, 1'b0, 7'h12, 5'd31, 16'h0035);
      @(negedge clk);
      idle();
      @(negedge clk);
      check("trunc_word", 32'(bus.Instruction_o), 32'h025FA800);
      check("trunc_set", 32'(bus.truncErr_o), 32'd1);
      repeat (3) @(negedge clk);
      check("trunc_sticky", 32'(bus.truncErr_o), 32'd1);

      // Fill under stall: fifth offer ignored, outputs frozen, then ordered drain.
      bus.shouldStalled_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 7'(i + 1), 5'(i), 16'(i * 3));
         @(negedge clk);
         if (i >= 3) check("full_ready_o", 32'(bus.ready_o), 32'd0);
      end
      idle();
      check("stall_enable_frozen", 32'(bus.enable_o), 32'd0);
      check("stall_word_frozen", 32'(bus.Instruction_o), 32'h025FA800);
      bus.shouldStalled_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("drain_enable_o", 32'(bus.enable_o), 32'd1);
         check("drain_opcode", 32'(bus.Instruction_o[27:21]), 32'(i + 1));
      end
      @(negedge clk);
      check("drain_done_enable_o", 32'(bus.enable_o), 32'd0);

      // Full FIFO: offer and unstall on the same edge.
      bus.shouldStalled_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 7'(8'h20 + i), 5'(i), 16'h1234);
         @(negedge clk);
      end
      drive(1'b1, 1'b0, 7'h7F, 5'd9, 16'hFFFF);
      bus.shouldStalled_i = 1'b0;
      @(negedge clk);
      idle();
      check("full_pop_enable_o", 32'(bus.enable_o), 32'd1);
      check("full_pop_head", 32'(bus.Instruction_o[27:21]), 32'h20);
      check("full_pop_ready_o", 32'(bus.ready_o), 32'd1);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         check("full_rest_opcode", 32'(bus.Instruction_o[27:21]), 32'(8'h20 + i));
      end
      @(negedge clk);
      check("full_no_extra", 32'(bus.enable_o), 32'd0);

      // Streaming across pointer wrap.
      maxq = 0;
      for (int i = 0; i < 2 * DEPTH + 3; i++) begin
         drive(1'(i % 2), 1'b0, 7'(8'h40 + i), 5'(i), 16'(i));
         @(negedge clk);
         if (i > 0) check("stream_opcode", 32'(bus.Instruction_o[27:21]), 32'(8'h40 + i - 1));
      end
      idle();
      @(negedge clk);
      check("stream_last", 32'(bus.Instruction_o[27:21]), 32'(8'h40 + 2 * DEPTH + 2));
      check("stream_max_count", 32'(maxq <= 1), 32'd1);

      // Reset with entries queued discards them.
      bus.shouldStalled_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 7'(8'h50 + i), 5'd1, 16'h00AA);
         @(negedge clk);
      end
      idle();
      bus.shouldStalled_i = 1'b0;
      @(negedge clk);
      check("pre_reset_enable_o", 32'(bus.enable_o), 32'd1);
      rst = 1'b1;
      bus.shouldStalled_i = 1'b1;
      @(negedge clk);
      check("mid_rst_enable_o", 32'(bus.enable_o), 32'd0);
      check("mid_rst_instruction_o", 32'(bus.Instruction_o), 32'd0);
      check("mid_rst_format_o", 32'(bus.InstructionFormat_o), 32'd0);
      check("mid_rst_trunc_err_o", 32'(bus.truncErr_o), 32'd0);
      rst = 1'b0;
      bus.shouldStalled_i = 1'b0;
      check("post_rst_ready_o", 32'(bus.ready_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_quiet", 32'(bus.enable_o), 32'd0);
      end
      check("scoreboard_empty", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
